systolic_sequencer: RTL and testbench

Job controller for the N_SIZE×N_SIZE systolic multiply array. On a `start` request it:
- clears the array accumulators;
- streams one A column and one B row per cycle from the operand buffer into the array;
- captures the N_SIZE result rows the array emits and writes them to the result buffer;
- reports completion, or a timeout error.

It sits between the operand/result buffers and a single array instance and owns all array-side control.

---
 rtl/systolic_sequencer.sv | 175 +++++++++++++++++
 tb/tb_systolic_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// Job controller for an N_SIZE x N_SIZE systolic multiply array: clears the
// accumulators, streams operands from the operand buffer, and collects result rows.
module systolic_sequencer #(
  parameter int DATAWIDTH = 8,
  parameter int N_SIZE    = 3,
  parameter int TIMEOUT   = 64,
  parameter int AW        = (N_SIZE > 2) ? $clog2(N_SIZE) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            op_rd_en,
  output logic [AW-1:0]                   op_rd_addr,
  input  logic [2*N_SIZE*DATAWIDTH-1:0]   op_rd_data,
  output logic                            res_wr_en,
  output logic [AW-1:0]                   res_wr_addr,
  output logic [N_SIZE*2*DATAWIDTH-1:0]   res_wr_data,
  output logic                            arr_clear,
  output logic                            arr_valid_in,
  output logic [N_SIZE*DATAWIDTH-1:0]     arr_a,
  output logic [N_SIZE*DATAWIDTH-1:0]     arr_b,
  input  logic                            arr_valid_out,
  input  logic [N_SIZE*2*DATAWIDTH-1:0]   arr_c
);

  localparam int              OPW    = N_SIZE * DATAWIDTH;
  localparam int              TW     = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]   LAST   = AW'(N_SIZE - 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   step_q;
  logic [AW-1:0]   beat_q;
  logic [TW-1:0]   tcnt_q;
  logic            kill;
  logic            accept;
  logic            last_beat;
  logic            expire;

  assign kill   = abort && (state != S_IDLE);
  assign accept = (state == S_IDLE) && start;

  // NOTE: every register here uses non-blocking assignments so all flops
  // update from the same pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output and next-state term is defaulted first so no path
  // through the case leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt    = state;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    arr_clear    = 1'b0;
    arr_valid_in = 1'b0;
    arr_a        = '0;
    arr_b        = '0;
    res_wr_en    = 1'b0;
    res_wr_addr  = '0;
    res_wr_data  = '0;
    last_beat    = 1'b0;
    expire       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        arr_clear = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        arr_valid_in = 1'b1;
        arr_a        = op_rd_data[OPW-1:0];
        arr_b        = op_rd_data[2*OPW-1:OPW];
        if (step_q == LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (arr_valid_out) begin
          res_wr_en   = 1'b1;
          res_wr_addr = beat_q;
          res_wr_data = arr_c;
          last_beat   = (beat_q == LAST);
        end
        if (last_beat) begin
          state_nxt = S_DONE;
        end else if (tcnt_q == T_LAST) begin
          expire    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Cancel overrides everything: clear the array, suppress every strobe.
    if (kill) begin
      state_nxt    = S_IDLE;
      arr_clear    = 1'b1;
      done         = 1'b0;
      arr_valid_in = 1'b0;
      arr_a        = '0;
      arr_b        = '0;
      res_wr_en    = 1'b0;
      res_wr_addr  = '0;
      res_wr_data  = '0;
      last_beat    = 1'b0;
      expire       = 1'b0;
    end
  end

  // Step, beat and drain-cycle counters restart whenever their state is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      beat_q <= '0;
      tcnt_q <= '0;
    end else begin
      if (state == S_FEED && state_nxt == S_FEED) step_q <= step_q + 1'b1;
      else                                        step_q <= '0;

      if (state_nxt != S_DRAIN) beat_q <= '0;
      else if (res_wr_en)       beat_q <= beat_q + 1'b1;

      if (state == S_DRAIN && state_nxt == S_DRAIN) tcnt_q <= tcnt_q + 1'b1;
      else                                          tcnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      error <= 1'b0;
    else if (accept) error <= 1'b0;
    else if (expire) error <= 1'b1;
  end

  // Reads run one cycle ahead of FEED: address k is presented in the cycle
  // before step k, starting in CLEAR, so data lands exactly on its step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rd_en   <= 1'b0;
      op_rd_addr <= '0;
    end else if (kill) begin
      op_rd_en   <= 1'b0;
      op_rd_addr <= '0;
    end else if (accept) begin
      op_rd_en   <= 1'b1;
      op_rd_addr <= '0;
    end else if (op_rd_en) begin
      if (op_rd_addr == LAST) begin
        op_rd_en   <= 1'b0;
        op_rd_addr <= '0;
      end else begin
        op_rd_addr <= op_rd_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer: behavioural operand buffer and array,
// directed jobs with hand-computed result rows, monitor-side comparison.
module tb_systolic_sequencer;

  localparam int DW  = 8;
  localparam int N   = 3;
  localparam int TO  = 64;
  localparam int AW  = 2;
  localparam int CW  = 2 * DW;
  localparam int OPW = N * DW;
  localparam int RW  = N * CW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            busy, done, error;
  logic            op_rd_en;
  logic [AW-1:0]   op_rd_addr;
  logic [2*OPW-1:0] op_rd_data = '0;
  logic            res_wr_en;
  logic [AW-1:0]   res_wr_addr;
  logic [RW-1:0]   res_wr_data;
  logic            arr_clear, arr_valid_in;
  logic [OPW-1:0]  arr_a, arr_b;
  logic            arr_valid_out = 1'b0;
  logic [RW-1:0]   arr_c = '0;

  systolic_sequencer #(.DATAWIDTH(DW), .N_SIZE(N), .TIMEOUT(TO), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error),
    .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr), .op_rd_data(op_rd_data),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .arr_clear(arr_clear), .arr_valid_in(arr_valid_in), .arr_a(arr_a), .arr_b(arr_b),
    .arr_valid_out(arr_valid_out), .arr_c(arr_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [RW-1:0] data; } wr_t;
  typedef struct { bit err; int cyc; } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    rd_log[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Operand buffer contents and array behaviour knobs, set while idle.
  logic [2*OPW-1:0] opmem [N];
  int m_first = 0;
  int m_gap   = 0;
  bit m_on    = 1'b1;

  function automatic logic [2*OPW-1:0] opw(input int a0, a1, a2, b0, b1, b2);
    return {DW'(b2), DW'(b1), DW'(b0), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  function automatic logic [RW-1:0] row3(input int c0, c1, c2);
    return {CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  task automatic push_rows(input logic [RW-1:0] r0, r1, r2);
    wr_q.push_back('{addr: AW'(0), data: r0});
    wr_q.push_back('{addr: AW'(1), data: r1});
    wr_q.push_back('{addr: AW'(2), data: r2});
  endtask

  // Operand buffer (1-cycle read) and outer-product accumulating array.
  logic [CW-1:0] acc [N][N];
  initial begin : models
    logic          s_clear, s_vin, s_rd;
    logic [AW-1:0] s_addr;
    logic [OPW-1:0] s_a, s_b;
    int  feed_cnt, didx, next_beat, sent;
    bit  active;
    feed_cnt = 0; didx = 0; next_beat = 0; sent = 0; active = 1'b0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = '0;
    forever begin
      @(negedge clk);
      s_clear = arr_clear; s_vin = arr_valid_in; s_a = arr_a; s_b = arr_b;
      s_rd = op_rd_en; s_addr = op_rd_addr;
      @(posedge clk); #1;
      op_rd_data    = s_rd ? opmem[s_addr] : '0;
      arr_valid_out = 1'b0;
      arr_c         = '0;
      if (s_clear) begin
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = '0;
        feed_cnt = 0;
        active   = 1'b0;
      end else if (s_vin) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] = acc[i][j] + CW'(s_a[i*DW +: DW]) * CW'(s_b[j*DW +: DW]);
        feed_cnt++;
        if (feed_cnt == N) begin
          active = 1'b1; didx = 0; next_beat = m_first; sent = 0;
        end
      end
      if (active) begin
        if (m_on && sent < N && didx == next_beat) begin
          arr_valid_out = 1'b1;
          for (int j = 0; j < N; j++) arr_c[j*CW +: CW] = acc[sent][j];
          sent++;
          next_beat += m_gap + 1;
        end
        didx++;
        if (sent == N || didx > 2 * TO) active = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes a row or signals done.
  initial begin : monitor
    wr_t   w;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (op_rd_en) rd_log.push_back(int'(op_rd_addr));
        if (res_wr_en) begin
          if (wr_q.size() == 0) check("unexpected_write", res_wr_en, 0);
          else begin
            w = wr_q.pop_front();
            check("wr_addr", res_wr_addr, w.addr);
            check("wr_data", res_wr_data, w.data);
          end
        end
        if (done) begin
          check("done_no_write", res_wr_en, 0);
          if (done_q.size() == 0) check("unexpected_done", done, 0);
          else begin
            d = done_q.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("done_error", error, d.err);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_rd_en"}, op_rd_en, 0);
    check({tag, "_rd_addr"}, op_rd_addr, 0);
    check({tag, "_wr_en"}, res_wr_en, 0);
    check({tag, "_wr_addr"}, res_wr_addr, 0);
    check({tag, "_wr_data"}, res_wr_data, 0);
    check({tag, "_clear"}, arr_clear, 0);
    check({tag, "_vin"}, arr_valid_in, 0);
    check({tag, "_a"}, arr_a, 0);
    check({tag, "_b"}, arr_b, 0);
  endtask

  task automatic run_job(input int first, input int gap, input bit beats_on, input bit exp_err,
                         input int exp_len, input bit poke_start, input bit abort_with_start);
    int t0;
    int n;
    m_first = first; m_gap = gap; m_on = beats_on;
    rd_log.delete();
    t0 = cyc;
    done_q.push_back('{err: exp_err, cyc: t0 + exp_len});
    start = 1'b1;
    abort = abort_with_start;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("clear_cycle", arr_clear, 1);
    check("busy_rise", busy, 1);
    check("error_cleared", error, 0);
    check("rd0_en", op_rd_en, 1);
    check("rd0_addr", op_rd_addr, 0);
    for (int k = 0; k < N; k++) begin
      step();
      start = (poke_start && k == 0);
      @(negedge clk);
      check("feed_valid", arr_valid_in, 1);
      check("feed_a", arr_a, opmem[k][OPW-1:0]);
      check("feed_b", arr_b, opmem[k][2*OPW-1:OPW]);
    end
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      step();
      @(negedge clk);
      n++;
    end
    check("job_ends", busy, 0);
    check("rd_count", rd_log.size(), N);
    for (int i = 0; i < rd_log.size() && i < N; i++) check("rd_order", rd_log[i], i);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    #1;
    check_all_zero("reset");
    #20;
    rst_n = 1'b1;
    repeat (2) begin
      step();
      @(negedge clk);
      check("idle_busy", busy, 0);
    end

    // Identity x B: rows come back as B.
    opmem[0] = opw(1, 0, 0, 1, 2, 3);
    opmem[1] = opw(0, 1, 0, 4, 5, 6);
    opmem[2] = opw(0, 0, 1, 7, 8, 9);
    push_rows(row3(1, 2, 3), row3(4, 5, 6), row3(7, 8, 9));
    step();
    run_job(0, 0, 1'b1, 1'b0, 2 * N + 2, 1'b0, 1'b0);

    // All 255: 3*255*255 = 195075 wraps to 64003; start poked during FEED.
    for (int k = 0; k < N; k++) opmem[k] = opw(255, 255, 255, 255, 255, 255);
    push_rows(row3(64003, 64003, 64003), row3(64003, 64003, 64003), row3(64003, 64003, 64003));
    step();
    run_job(0, 0, 1'b1, 1'b0, 2 * N + 2, 1'b1, 1'b0);

    // Timeout: no beats, done after TO drain cycles with error set.
    opmem[0] = opw(1, 0, 0, 1, 2, 3);
    opmem[1] = opw(0, 1, 0, 4, 5, 6);
    opmem[2] = opw(0, 0, 1, 7, 8, 9);
    step();
    run_job(0, 0, 1'b0, 1'b1, N + 2 + TO, 1'b0, 1'b0);
    repeat (3) step();
    @(negedge clk);
    check("error_sticky", error, 1);

    // Next start clears the error.
    push_rows(row3(1, 2, 3), row3(4, 5, 6), row3(7, 8, 9));
    step();
    run_job(0, 0, 1'b1, 1'b0, 2 * N + 2, 1'b0, 1'b0);

    // Abort at FEED step 1 with a stray start during FEED.
    m_first = 0; m_gap = 0; m_on = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("abort_clear", arr_clear, 1);
    check("abort_no_done", done, 0);
    check("abort_no_write", res_wr_en, 0);
    check("abort_no_vin", arr_valid_in, 0);
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_clear_drop", arr_clear, 0);
    repeat (12) step();
    @(negedge clk);
    check("abort_stays_idle", busy, 0);

    // Reset mid-FEED: outputs drop asynchronously, no busy afterwards.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    step();
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      @(negedge clk);
      check("post_reset_busy", busy, 0);
    end

    // Stalled array: beats at DRAIN+5, +8, +11; abort with start in IDLE is ignored.
    opmem[0] = opw(1, 0, 3, 1, 0, 2);
    opmem[1] = opw(2, 1, 0, 0, 1, 1);
    opmem[2] = opw(0, 1, 2, 2, 1, 0);
    push_rows(row3(1, 2, 4), row3(2, 2, 1), row3(7, 2, 6));
    step();
    run_job(5, 2, 1'b1, 1'b0, N + 2 + 5 + 6 + 1, 1'b1, 1'b1);

    repeat (3) step();
    check("wr_q_drained", wr_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
